call_account: RTL and testbench

- Prepaid-card telephone billing controller for a payphone line.
- Holds the card balance as 3-digit BCD (tens of yuan, yuan, jiao); the balance is loaded by keys and shown continuously.
- During a call it counts minutes, charges per started minute by call category, warns on low balance and cuts the line when funds run out.
- Sits between the card reader/keypad front end and the line relay/display drivers.

---
 rtl/call_account.sv | 200 ++++++++++++++++++++
 tb/tb_call_account.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_account.sv
// Prepaid-card payphone billing controller.
// Keeps a 3-digit BCD balance (tens of yuan, yuan, jiao) that is loaded by keys
// while idle and charged per started minute during a call. Raises a low-balance
// warning and cuts the line once the balance no longer covers a minute.
// Optional build macro WARN_BEEP_EN: when defined the speaker toggles on every
// 4 Hz tick while warn is high; when undefined the speaker output is tied to 0.

module call_account #(
  parameter int          DIV_4HZ    = 250,
  parameter int          MIN_TICKS  = 240,
  parameter logic [11:0] LOCAL_RATE = 12'h003,
  parameter logic [11:0] LONG_RATE  = 12'h006
) (
  input  logic        clk_1kHz,
  input  logic        clrn,
  input  logic        card,
  input  logic        on,
  input  logic [1:0]  category,
  input  logic        set_money_high,
  input  logic        set_money_mid,
  input  logic        set_money_low,
  output logic [7:0]  disptime,
  output logic [11:0] dispmoney,
  output logic        read,
  output logic        write,
  output logic        warn,
  output logic        cut,
  output logic        speaker
);

  localparam int DIV_W = (DIV_4HZ > 1) ? $clog2(DIV_4HZ) : 1;
  localparam int MIN_W = (MIN_TICKS > 1) ? $clog2(MIN_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_4HZ - 1);
  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALL = 2'd1,
    CUT  = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [MIN_W-1:0] min_cnt;
  logic [11:0]      balance;
  logic [11:0]      rate;
  logic             card_d;
  logic             called;
  logic             tick;
  logic             cat_ok;
  logic [11:0]      sel_rate;
  logic [11:0]      start_balance;
  logic [11:0]      charged_balance;

  // Three-digit BCD subtraction with ripple borrow; callers guarantee a >= b.
  function automatic logic [11:0] bcd_sub(input logic [11:0] a, input logic [11:0] b);
    logic [11:0] r;
    logic        borrow;
    logic [4:0]  d;
    r      = '0;
    borrow = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0, borrow};
      if (d[4]) begin
        d      = d + 5'd10;
        borrow = 1'b1;
      end else begin
        borrow = 1'b0;
      end
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  // Single BCD digit increment that wraps 9 -> 0 without carrying out.
  function automatic logic [3:0] bcd_digit_inc(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  // Two-digit BCD minute increment that sticks at 99.
  function automatic logic [7:0] bcd_min_inc(input logic [7:0] t);
    if (t == 8'h99)
      return t;
    if (t[3:0] == 4'd9)
      return {t[7:4] + 4'd1, 4'd0};
    return {t[7:4], t[3:0] + 4'd1};
  endfunction

  assign tick            = (div_cnt == DIV_LAST);
  assign cat_ok          = (category == 2'b01) || (category == 2'b10);
  assign sel_rate        = (category == 2'b10) ? LONG_RATE : LOCAL_RATE;
  assign start_balance   = bcd_sub(balance, sel_rate);
  assign charged_balance = bcd_sub(balance, rate);
  assign dispmoney       = balance;

  // Free-running divider producing the 4 Hz tick enable.
  always_ff @(posedge clk_1kHz or negedge clrn) begin
    if (!clrn)
      div_cnt <= '0;
    else if (tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // Billing state machine: card edge pulses, key loading, call charging and cut-off.
  always_ff @(posedge clk_1kHz or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      min_cnt  <= '0;
      balance  <= '0;
      rate     <= '0;
      disptime <= '0;
      card_d   <= 1'b0;
      called   <= 1'b0;
      read     <= 1'b0;
      write    <= 1'b0;
      warn     <= 1'b0;
      cut      <= 1'b0;
    end else begin
      card_d <= card;
      read   <= card & ~card_d;
      write  <= ~card & card_d & called;
      if (card & ~card_d)
        called <= 1'b0;

      case (state)
        IDLE: begin
          if (card && on && cat_ok && !cut && (balance >= sel_rate)) begin
            state    <= CALL;
            rate     <= sel_rate;
            balance  <= start_balance;
            disptime <= 8'h01;
            min_cnt  <= '0;
            warn     <= (start_balance < sel_rate);
            called   <= 1'b1;
          end else if (tick) begin
            if (!set_money_high) balance[11:8] <= bcd_digit_inc(balance[11:8]);
            if (!set_money_mid)  balance[7:4]  <= bcd_digit_inc(balance[7:4]);
            if (!set_money_low)  balance[3:0]  <= bcd_digit_inc(balance[3:0]);
          end
        end

        CALL: begin
          if (!card || !on) begin
            state <= IDLE;
            warn  <= 1'b0;
          end else if (tick) begin
            if (min_cnt == MIN_LAST) begin
              min_cnt <= '0;
              if (balance >= rate) begin
                balance  <= charged_balance;
                disptime <= bcd_min_inc(disptime);
                warn     <= (charged_balance < rate);
              end else begin
                cut   <= 1'b1;
                state <= CUT;
              end
            end else begin
              min_cnt <= min_cnt + 1'b1;
            end
          end
        end

        CUT: begin
          if (!card || !on) begin
            state <= IDLE;
            cut   <= 1'b0;
            warn  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cut   <= 1'b0;
          warn  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WARN_BEEP_EN
  logic speaker_q;

  // Warning tone: flips on every tick while warn is high, silent otherwise.
  always_ff @(posedge clk_1kHz or negedge clrn) begin
    if (!clrn)
      speaker_q <= 1'b0;
    else if (!warn)
      speaker_q <= 1'b0;
    else if (tick)
      speaker_q <= ~speaker_q;
  end

  assign speaker = speaker_q & warn;
`else
  assign speaker = 1'b0;
`endif

endmodule

// File: tb/tb_call_account.sv
// Directed bench for call_account with a scoreboard queue of expected
// output snapshots; small DIV_4HZ / MIN_TICKS keep the run short.

module tb_call_account;

  localparam int DIV = 4;
  localparam int MIN = 8;

  logic        clk_1kHz;
  logic        clrn;
  logic        card;
  logic        on;
  logic [1:0]  category;
  logic        set_money_high;
  logic        set_money_mid;
  logic        set_money_low;
  logic [7:0]  disptime;
  logic [11:0] dispmoney;
  logic        read;
  logic        write;
  logic        warn;
  logic        cut;
  logic        speaker;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [11:0] money;
    logic [7:0]  mins;
    logic        rd;
    logic        wr;
    logic        wn;
    logic        ct;
  } exp_t;

  exp_t exp_q[$];

  call_account #(
    .DIV_4HZ   (DIV),
    .MIN_TICKS (MIN),
    .LOCAL_RATE(12'h003),
    .LONG_RATE (12'h006)
  ) dut (
    .clk_1kHz      (clk_1kHz),
    .clrn          (clrn),
    .card          (card),
    .on            (on),
    .category      (category),
    .set_money_high(set_money_high),
    .set_money_mid (set_money_mid),
    .set_money_low (set_money_low),
    .disptime      (disptime),
    .dispmoney     (dispmoney),
    .read          (read),
    .write         (write),
    .warn          (warn),
    .cut           (cut),
    .speaker       (speaker)
  );

  // 1 kHz stand-in clock
  initial clk_1kHz = 1'b0;
  always #5 clk_1kHz = ~clk_1kHz;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_1kHz);
  endtask

  // keys_n is {high, mid, low}, active low
  task automatic applyStimulus(input logic c, input logic o, input logic [1:0] cat,
                               input logic [2:0] keys_n);
    card     = c;
    on       = o;
    category = cat;
    {set_money_high, set_money_mid, set_money_low} = keys_n;
  endtask

  task automatic pushExp(input string tag, input logic [11:0] m, input logic [7:0] t,
                         input logic rd, input logic wr, input logic wn, input logic ct);
    exp_t e;
    e.tag   = tag;
    e.money = m;
    e.mins  = t;
    e.rd    = rd;
    e.wr    = wr;
    e.wn    = wn;
    e.ct    = ct;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    cmp({e.tag, ".money"}, dispmoney, e.money);
    cmp({e.tag, ".time"},  disptime,  e.mins);
    cmp({e.tag, ".read"},  read,      e.rd);
    cmp({e.tag, ".write"}, write,     e.wr);
    cmp({e.tag, ".warn"},  warn,      e.wn);
    cmp({e.tag, ".cut"},   cut,       e.ct);
`ifdef WARN_BEEP_EN
    if (!e.wn) cmp({e.tag, ".speaker"}, speaker, 1'b0);
`else
    cmp({e.tag, ".speaker"}, speaker, 1'b0);
`endif
  endtask

  initial begin
    logic spk0;
    logic spk_exp;

    clrn = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);

    // reset state
    cycles(2);
    pushExp("reset", 12'h000, 8'h00, 0, 0, 0, 0);
    checkOutput();
    clrn = 1'b1;

    // load balance: high 8 ticks, mid 7 ticks, low 8 ticks
    cycles(1);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b011);
    cycles(8 * DIV);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b101);
    cycles(7 * DIV);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b110);
    cycles(8 * DIV);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);
    pushExp("load", 12'h878, 8'h00, 0, 0, 0, 0);
    checkOutput();

    // local call: card insertion pulse, then connect
    applyStimulus(1'b1, 1'b0, 2'b01, 3'b111);
    pushExp("insert", 12'h878, 8'h00, 1, 0, 0, 0);
    cycles(1);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 2'b01, 3'b111);
    pushExp("local_start", 12'h875, 8'h01, 0, 0, 0, 0);
    cycles(1);
    checkOutput();

    // keys pressed mid-call and a category change are ignored
    applyStimulus(1'b1, 1'b1, 2'b10, 3'b110);
    cycles(4 * DIV);
    applyStimulus(1'b1, 1'b1, 2'b01, 3'b111);
    pushExp("local_keys", 12'h875, 8'h01, 0, 0, 0, 0);
    cycles(DIV);
    checkOutput();

    // second started minute charged at the local rate
    pushExp("local_min2", 12'h872, 8'h02, 0, 0, 0, 0);
    cycles(4 * DIV);
    checkOutput();

    // card removal ends the call with a write-back pulse
    applyStimulus(1'b0, 1'b1, 2'b01, 3'b111);
    pushExp("local_remove", 12'h872, 8'h02, 0, 1, 0, 0);
    cycles(1);
    checkOutput();
    pushExp("local_after", 12'h872, 8'h02, 0, 0, 0, 0);
    cycles(1);
    checkOutput();

    // reset in the middle of a call
    applyStimulus(1'b1, 1'b1, 2'b01, 3'b111);
    pushExp("midcall_start", 12'h869, 8'h01, 1, 0, 0, 0);
    cycles(1);
    checkOutput();
    clrn = 1'b0;
    #1;
    pushExp("midcall_reset", 12'h000, 8'h00, 0, 0, 0, 0);
    checkOutput();
    cycles(1);
    clrn = 1'b1;
    pushExp("zero_bal_idle", 12'h000, 8'h00, 0, 0, 0, 0);
    cycles(3);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 2'b01, 3'b111);
    pushExp("no_call_no_write", 12'h000, 8'h00, 0, 0, 0, 0);
    cycles(1);
    checkOutput();

    // load 01.0
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b101);
    cycles(DIV);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);
    pushExp("load_010", 12'h010, 8'h00, 0, 0, 0, 0);
    checkOutput();

    // long-distance call with low funds
    applyStimulus(1'b1, 1'b1, 2'b10, 3'b111);
    pushExp("long_start", 12'h004, 8'h01, 1, 0, 1, 0);
    cycles(1);
    checkOutput();
`ifdef WARN_BEEP_EN
    spk0    = speaker;
    spk_exp = ~spk0;
    cycles(DIV);
    cmp("long.speaker_toggle", speaker, spk_exp);
`else
    spk0 = 1'b0;
    spk_exp = 1'b0;
    cycles(DIV);
`endif
    pushExp("long_warn", 12'h004, 8'h01, 0, 0, 1, 0);
    cycles(4 * DIV);
    checkOutput();
    pushExp("long_cut", 12'h004, 8'h01, 0, 0, 1, 1);
    cycles(4 * DIV);
    checkOutput();
    applyStimulus(1'b1, 1'b0, 2'b10, 3'b111);
    pushExp("long_hangup", 12'h004, 8'h01, 0, 0, 0, 0);
    cycles(1);
    checkOutput();

    // refused call: balance below long-distance rate
    applyStimulus(1'b1, 1'b1, 2'b10, 3'b111);
    pushExp("refused", 12'h004, 8'h01, 0, 0, 0, 0);
    cycles(3);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);
    pushExp("long_remove", 12'h004, 8'h01, 0, 1, 0, 0);
    cycles(1);
    checkOutput();

    // balance exactly equal to the rate still connects
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b110);
    cycles(2 * DIV);
    applyStimulus(1'b0, 1'b0, 2'b00, 3'b111);
    pushExp("load_006", 12'h006, 8'h01, 0, 0, 0, 0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 2'b10, 3'b111);
    pushExp("exact_start", 12'h000, 8'h01, 1, 0, 1, 0);
    cycles(1);
    checkOutput();
    applyStimulus(1'b0, 1'b1, 2'b10, 3'b111);
    pushExp("exact_remove", 12'h000, 8'h01, 0, 1, 0, 0);
    cycles(1);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
